// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_muldiv_unit
// Purpose  : Iterative unsigned shift-add multiplier / restoring divider that
//            issues one register-file write per accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module seq_muldiv_unit #(
    parameter int data_width   = 32,
    parameter int select_width = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [data_width-1:0]   operand_a,
    input  logic [data_width-1:0]   operand_b,
    input  logic [select_width-1:0] dest_addr,
    input  logic                    flush,
    output logic                    busy,
    output logic                    RegWrite,
    output logic [select_width-1:0] write_address,
    output logic [data_width-1:0]   write_data
);

    localparam int c_cnt_w = $clog2(data_width + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [c_cnt_w-1:0]        r_count;
    logic [1:0]                r_op;
    logic [select_width-1:0]   r_dest;
    logic [data_width-1:0]     r_opa;
    logic [data_width-1:0]     r_opb;
    logic [2*data_width-1:0]   r_prod;
    logic [data_width-1:0]     r_rem;
    logic [data_width-1:0]     r_quo;

    logic                      w_accept;
    logic                      w_step;
    logic                      w_last;
    logic [data_width:0]       w_addend;
    logic [data_width:0]       w_sum;
    logic [2*data_width-1:0]   w_prod_next;
    logic [data_width:0]       w_shift;
    logic [data_width:0]       w_diff;
    logic                      w_ge;
    logic                      w_diff_unused;
    logic [data_width-1:0]     w_rem_next;
    logic [data_width-1:0]     w_quo_next;
    logic [data_width-1:0]     w_result;

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_step   = (r_state == S_RUN) && !flush;
    assign w_last   = (r_count == c_cnt_w'(1));

    // Shift-add step: the multiplier sits in the low half and is consumed LSB first.
    assign w_addend    = r_prod[0] ? {1'b0, r_opa} : '0;
    assign w_sum       = {1'b0, r_prod[2*data_width-1:data_width]} + w_addend;
    assign w_prod_next = {w_sum, r_prod[data_width-1:1]};

    // Restoring step; a zero divisor always subtracts, giving all-ones / dividend.
    assign w_shift       = {r_rem, r_quo[data_width-1]};
    assign w_ge          = (w_shift >= {1'b0, r_opb});
    assign w_diff        = w_shift - {1'b0, r_opb};
    assign w_diff_unused = w_diff[data_width];
    assign w_rem_next    = w_ge ? w_diff[data_width-1:0] : w_shift[data_width-1:0];
    assign w_quo_next    = {r_quo[data_width-2:0], w_ge};

    always_comb begin
        w_result = '0;
        case (r_op)
            2'b00:   w_result = w_prod_next[data_width-1:0];
            2'b01:   w_result = w_prod_next[2*data_width-1:data_width];
            2'b10:   w_result = w_quo_next;
            default: w_result = w_rem_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        RegWrite     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && start) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (flush)       w_next_state = S_IDLE;
                else if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                RegWrite     = !flush;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_op          <= '0;
            r_dest        <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            r_prod        <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            write_data    <= '0;
            write_address <= '0;
        end else if (w_accept) begin
            r_count <= c_cnt_w'(data_width);
            r_op    <= op;
            r_dest  <= dest_addr;
            r_opa   <= operand_a;
            r_opb   <= operand_b;
            r_prod  <= {{data_width{1'b0}}, operand_b};
            r_rem   <= '0;
            r_quo   <= operand_a;
        end else if (w_step) begin
            r_count <= r_count - c_cnt_w'(1);
            r_prod  <= w_prod_next;
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            if (w_last) begin
                write_data    <= w_result;
                write_address <= r_dest;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_muldiv_unit.md
# seq_muldiv_unit

Iterative unsigned multiply/divide unit that sits directly downstream of `nbit_register_file`'s read ports and upstream of its write port. It latches two register operands and a destination address, computes over `data_width` cycles (shift-add multiply or restoring divide), then issues a single-cycle write request (`RegWrite`, `write_address`, `write_data`). These three outputs connect directly to the register file's write port. Single-cycle ALU writes are muxed externally and hold off while `RegWrite` from this block is high.

## Interface
- `data_width`, 32, operand/result width; must match the register file.
- `select_width`, 5, register address width; must match the register file.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MUL low word, 01 MUL high word, 10 DIV quotient, 11 REM remainder (all unsigned).
- `operand_a`  in  `data_width`  multiplicand / dividend; sourced from register file `read_data_1`.
- `operand_b`  in  `data_width`  multiplier / divisor; sourced from register file `read_data_2`.
- `dest_addr`  in  `select_width`  destination register.
- `flush`  in  1  synchronous abort.
- `busy`  out  1  high while not in IDLE.
- `RegWrite`  out  1  one-cycle write strobe.
- `write_address`  out  `select_width`  destination register for the write.
- `write_data`  out  `data_width`  result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: if `start`=1, latch `op`, `operand_a`, `operand_b`, `dest_addr`; load step counter = `data_width`; go to RUN.
  - RUN: perform one iteration per cycle and decrement the counter. When an iteration executes with counter = 1, go to DONE.
  - DONE: `RegWrite`=1 for exactly this cycle; go to IDLE.
- Multiply: shift-add over a 2×`data_width` product register.
  - op 00 returns product bits [`data_width`-1:0].
  - op 01 returns product bits [2·`data_width`-1:`data_width`].
- Divide: restoring algorithm with a `data_width`+1-bit partial remainder. No early termination.
- Divide by zero (`operand_b`=0 latched):
  - op 10 returns all ones.
  - op 11 returns the latched dividend.
  - Latency is unchanged.
- `write_data` and `write_address` are registered. They are loaded on entry to DONE and hold their value until the next DONE; they are meaningful only while `RegWrite`=1.
- Address 0 is written like any other address; this block does not treat register 0 specially.
- `start` while `busy`=1 is ignored; no queueing. The issuing logic must wait for `busy`=0.
- `flush`=1 in RUN or DONE returns the FSM to IDLE next edge.
  - `RegWrite` is forced to 0 in that same cycle, so no write occurs.
  - `flush` in IDLE has priority over `start`.
- Operands are latched at the start edge; later changes on the register file read ports do not affect the result.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, counter 0, `busy`=0, `RegWrite`=0, `write_data`=0, `write_address`=0. All internal operand and product registers clear to 0.
- Reset release is synchronous to `clk`; the first `start` is sampled on the first rising edge with `rst_n`=1.
- Edge numbering: `start` sampled at edge T0.
  - RUN occupies edges T1..T`data_width`.
  - DONE is visible after edge T`data_width`.
  - The register file captures the result at edge T`data_width`+1.
  - FSM is back in IDLE after T`data_width`+1.
- `busy` is high from after T0 through the DONE cycle. The earliest next accepted `start` is at edge T`data_width`+2.
- Back-to-back throughput: one result per `data_width`+2 cycles.
- Reset asserted mid-RUN or in DONE: immediate return to the reset state; no `RegWrite` pulse is produced.

## Test plan
- Basic multiply: `op`=00, a=7, b=6, dest=3 -> `RegWrite` pulse exactly once, 32 cycles after the start edge; `write_address`=3, `write_data`=42; the register file then reads back 42 at address 3.
- High-word multiply: `op`=01, a=0xFFFFFFFF, b=0xFFFFFFFF -> `write_data`=0xFFFFFFFE. A rerun with `op`=00 -> 0x00000001.
- Divide pair: a=100, b=7 -> `op`=10 gives 14 and `op`=11 gives 2. Also a=5, b=9 -> quotient 0, remainder 5.
- Divide by zero: a=0x1234, b=0 -> `op`=10 gives 0xFFFFFFFF, `op`=11 gives 0x1234; latency is the same as a normal divide.
- Busy rule:
  - Assert `start` with different operands at T5 and in the DONE cycle -> both ignored; only the original result is written.
  - A `start` at T`data_width`+2 is accepted.
- Abort:
  - `flush` at T10 -> `busy`=0 next cycle and no `RegWrite`.
  - `rst_n` low at T20 -> all outputs go to 0 immediately and no `RegWrite`.
  - A new op after either abort completes correctly.
